// File: rtl/rom_load_receiver.sv
`default_nettype none
// ============================================================================
// Module      : rom_load_receiver
// Description : Responder end of the ROM-loading handshake. Each word from
//               the on-board loader is written through a request/ready/done
//               port into the QSPI ROM controller at sequential addresses
//               starting from 0. The Hack CPU is held in reset (cpu_hold)
//               while a load session is open or a write is still in flight.
//               Optional macro ROM_LOADER_CHECKSUM_EN adds a running
//               mod-2**DATA_WIDTH sum of the committed words; without it,
//               checksum is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_load_receiver #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_WORDS     = 32768
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rom_loader_reset,
  input  logic                     rom_loader_load,
  input  logic [DATA_WIDTH-1:0]    rom_loader_data,
  output logic                     rom_loader_load_received,
  output logic                     rom_loader_ack,
  output logic                     mem_request,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data,
  input  logic                     mem_ready,
  input  logic                     mem_done,
  output logic                     cpu_hold,
  output logic [ADDRESS_WIDTH:0]   words_loaded,
  output logic                     overflow,
  output logic [DATA_WIDTH-1:0]    checksum
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_LOAD    = 3'd1,
    S_REQ          = 3'd2,
    S_WAIT_DONE    = 3'd3,
    S_ACK          = 3'd4,
    S_WAIT_RELEASE = 3'd5
  } state_t;

  localparam logic [ADDRESS_WIDTH:0] c_max_words = (ADDRESS_WIDTH+1)'(MAX_WORDS);

  state_t                   r_state;
  state_t                   w_next;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [ADDRESS_WIDTH:0]   r_words;
  logic                     r_overflow;
  logic                     w_clear;
  logic                     w_latch;
  logic                     w_commit;
  logic                     w_set_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs; session close takes priority over a new load
  always_comb begin
    w_next                   = r_state;
    rom_loader_load_received = 1'b0;
    rom_loader_ack           = 1'b0;
    mem_request              = 1'b0;
    w_clear                  = 1'b0;
    w_latch                  = 1'b0;
    w_commit                 = 1'b0;
    w_set_ovf                = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rom_loader_reset) begin
          w_clear = 1'b1;
          w_next  = S_WAIT_LOAD;
        end
      end
      S_WAIT_LOAD: begin
        if (!rom_loader_reset) begin
          w_next = S_IDLE;
        end else if (rom_loader_load) begin
          rom_loader_load_received = 1'b1;
          w_latch                  = 1'b1;
          if (r_words == c_max_words) begin
            w_set_ovf = 1'b1;
            w_next    = S_ACK;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_request = 1'b1;
        if (mem_ready) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // The write finishes even if the session closed meanwhile; only the ack is skipped
        if (mem_done) begin
          w_commit = 1'b1;
          w_next   = rom_loader_reset ? S_ACK : S_IDLE;
        end
      end
      S_ACK: begin
        rom_loader_ack = 1'b1;
        w_next         = rom_loader_reset ? S_WAIT_RELEASE : S_IDLE;
      end
      S_WAIT_RELEASE: begin
        if (!rom_loader_reset)     w_next = S_IDLE;
        else if (!rom_loader_load) w_next = S_WAIT_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word latch, committed-word counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= '0;
      r_words    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_clear) begin
        r_words    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_latch)   r_data     <= rom_loader_data;
      if (w_commit)  r_words    <= r_words + 1'b1;
      if (w_set_ovf) r_overflow <= 1'b1;
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of committed words, restarted at each session open
  always_ff @(posedge clk) begin
    if (reset)         r_checksum <= '0;
    else if (w_clear)  r_checksum <= '0;
    else if (w_commit) r_checksum <= r_checksum + r_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  // Address equals the committed count, which never exceeds MAX_WORDS, so it never wraps
  assign mem_address  = r_words[ADDRESS_WIDTH-1:0];
  assign mem_data     = r_data;
  assign words_loaded = r_words;
  assign overflow     = r_overflow;
  assign cpu_hold     = rom_loader_reset | (r_state == S_REQ) | (r_state == S_WAIT_DONE);

endmodule
`default_nettype wire
